// File: rtl/memory_access_pkg.sv
// memory_access_pkg
// Shared definitions for the memory access unit: FSM state encoding,
// default geometry and the timeout counter width helper.
// No ports (package).

`ifndef MEMORY_ACCESS_CNT_W
`define MEMORY_ACCESS_CNT_W(t) ($clog2((t) + 1))
`endif

package memory_access_pkg;

   localparam int DEFAULT_ADDRESS_WIDTH  = 8;
   localparam int DEFAULT_DATA_WIDTH     = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } mau_state_e;

   // Bits needed to hold a count from 0 up to and including timeout_cycles.
   function automatic int timeout_cnt_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/access_timeout_counter.sv
// access_timeout_counter
// Counts enabled cycles since the last clear and flags the cycle on which
// the count would reach the terminal value.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   clear          restart counting from zero
//   enable         count this cycle
//   terminal       number of enabled cycles that constitutes expiry
//   expired        high during the enabled cycle that completes the terminal count

module access_timeout_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] terminal,
   output logic             expired
);

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] last_count;

   // count_q holds the number of enabled cycles already completed, so the
   // current enabled cycle is the terminal one when count_q == terminal-1.
   assign last_count = terminal - CNT_W'(1);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != terminal)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   assign expired = enable && !clear && (count_q >= last_count);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit
// Request-side front end for data_memory: accepts one load/store at a time,
// drives the memory pins, waits for the memory ready flag (bounded by a
// timeout) and returns a response.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_write, req_address, req_data  request payload (1 = store)
//   resp_valid/resp_ready             response handshake
//   resp_data, resp_error             response payload
//   mem_address, mem_in               registered address / store data to memory
//   mem_out, mem_ready                load data and ready flag from memory
//   mem_read_signal, mem_write_signal one-cycle access strobes
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. The unit raises req_ready only in IDLE and holds
// resp_valid and the response payload stable until resp_ready is seen.

module memory_access_unit
   import memory_access_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDRESS_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0]    req_data,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DATA_WIDTH-1:0]    resp_data,
   output logic                     resp_error,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_in,
   input  logic [DATA_WIDTH-1:0]    mem_out,
   output logic                     mem_read_signal,
   output logic                     mem_write_signal,
   input  logic                     mem_ready
);

   localparam int CNT_W = `MEMORY_ACCESS_CNT_W(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES);

   mau_state_e               state_q, state_d;
   logic                     live_q, live_d;
   logic                     write_q, write_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
   logic                     resp_error_q, resp_error_d;

   logic cnt_clear;
   logic cnt_enable;
   logic cnt_expired;

   access_timeout_counter #(
      .CNT_W (CNT_W)
   ) u_timeout (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (cnt_clear),
      .enable   (cnt_enable),
      .terminal (TERMINAL),
      .expired  (cnt_expired)
   );

   // live_q is low for the cycle(s) following a sampled reset so that every
   // output, including req_ready, reads 0 while reset is held.
   assign req_ready        = live_q && (state_q == ST_IDLE);
   assign resp_valid       = (state_q == ST_RESPOND);
   assign resp_data        = resp_data_q;
   assign resp_error       = resp_error_q;
   assign mem_address      = addr_q;
   assign mem_in           = wdata_q;
   assign mem_read_signal  = (state_q == ST_ISSUE) && !write_q;
   assign mem_write_signal = (state_q == ST_ISSUE) &&  write_q;

   always_comb begin
      state_d      = state_q;
      live_d       = 1'b1;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_data_d  = resp_data_q;
      resp_error_d = resp_error_q;
      cnt_clear    = 1'b0;
      cnt_enable   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               write_d = req_write;
               addr_d  = req_address;
               wdata_d = req_data;
               state_d = ST_ISSUE;
            end
         end

         // mem_ready is deliberately ignored here: with an unchanged address
         // it still reflects the previous access.
         ST_ISSUE: begin
            cnt_clear = 1'b1;
            state_d   = ST_WAIT;
         end

         ST_WAIT: begin
            if (mem_ready) begin
               resp_data_d  = write_q ? '0 : mem_out;
               resp_error_d = 1'b0;
               state_d      = ST_RESPOND;
            end else begin
               cnt_enable = 1'b1;
               if (cnt_expired) begin
                  resp_data_d  = '0;
                  resp_error_d = 1'b1;
                  state_d      = ST_RESPOND;
               end
            end
         end

         ST_RESPOND: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         live_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         live_q       <= live_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
      end
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit
// Directed bench for memory_access_unit with a behavioural data_memory model
// (address-compare ready, optional extra latency, optional stuck-low ready)
// and an expected-response queue. A second instance with a short timeout
// and a permanently idle memory exercises the error response.

module tb_memory_access_unit;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT ----------------
   logic       req_valid, req_ready, req_write;
   logic [7:0] req_address, req_data;
   logic       resp_valid, resp_ready, resp_error;
   logic [7:0] resp_data;
   logic [7:0] mem_address, mem_in;
   logic [7:0] mem_out = 8'h00;
   logic       mem_read_signal, mem_write_signal, mem_ready;

   memory_access_unit #(
      .ADDRESS_WIDTH (8),
      .DATA_WIDTH    (8),
      .TIMEOUT_CYCLES(15)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_address     (req_address),
      .req_data        (req_data),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_data       (resp_data),
      .resp_error      (resp_error),
      .mem_address     (mem_address),
      .mem_in          (mem_in),
      .mem_out         (mem_out),
      .mem_read_signal (mem_read_signal),
      .mem_write_signal(mem_write_signal),
      .mem_ready       (mem_ready)
   );

   // ---------------- timeout DUT (memory never ready) ----------------
   logic       t_req_valid, t_req_ready, t_resp_valid, t_resp_ready, t_resp_error;
   logic [7:0] t_resp_data, t_mem_address, t_mem_in;
   logic       t_mem_read_signal, t_mem_write_signal;
   logic [7:0] t_mem_out = 8'h77;
   logic       t_mem_ready = 1'b0;

   memory_access_unit #(
      .ADDRESS_WIDTH (8),
      .DATA_WIDTH    (8),
      .TIMEOUT_CYCLES(3)
   ) dut_t3 (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (t_req_valid),
      .req_ready       (t_req_ready),
      .req_write       (1'b0),
      .req_address     (8'h20),
      .req_data        (8'h00),
      .resp_valid      (t_resp_valid),
      .resp_ready      (t_resp_ready),
      .resp_data       (t_resp_data),
      .resp_error      (t_resp_error),
      .mem_address     (t_mem_address),
      .mem_in          (t_mem_in),
      .mem_out         (t_mem_out),
      .mem_read_signal (t_mem_read_signal),
      .mem_write_signal(t_mem_write_signal),
      .mem_ready       (t_mem_ready)
   );

   // ---------------- memory model ----------------
   logic [7:0] mem_arr [0:255] = '{default: 8'h00};
   logic [7:0] lat_addr  = 8'h00;
   logic       lat_valid = 1'b0;
   int         pend = 0;
   int         slow_delay = 0;
   logic       poke_en = 1'b0;
   logic [7:0] poke_addr = 8'h00, poke_val = 8'h00;

   always @(posedge clk) begin
      if (poke_en) mem_arr[poke_addr] <= poke_val;
      if (mem_write_signal) mem_arr[mem_address] <= mem_in;
      if (mem_read_signal) mem_out <= mem_arr[mem_address];
      if (mem_read_signal || mem_write_signal) begin
         lat_addr  <= mem_address;
         lat_valid <= 1'b1;
         pend      <= slow_delay;
      end else if (pend > 0) begin
         pend <= pend - 1;
      end
   end

   assign mem_ready = lat_valid && (pend == 0) && (mem_address == lat_addr);

   // strobe monitor
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   always @(posedge clk) begin
      if (mem_read_signal) rd_cnt <= rd_cnt + 1;
      if (mem_write_signal) wr_cnt <= wr_cnt + 1;
      if ((mem_read_signal && mem_write_signal) || (t_mem_read_signal && t_mem_write_signal))
         both_cnt <= both_cnt + 1;
   end

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];   // {error, data}
   int         acc_edge = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_data, input logic track);
      int n;
      n = 0;
      req_valid   = 1'b1;
      req_write   = w;
      req_address = a;
      req_data    = d;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_accepted", 32'(n < 20), 1);
      acc_edge = cyc + 1;
      if (track) exp_q.push_back({1'b0, w ? 8'h00 : exp_data});
      @(negedge clk);
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_address = 8'h00;
      req_data    = 8'h00;
   endtask

   task automatic recv(input string tag, input int exp_lat, input int hold);
      int n;
      logic [8:0] e;
      n = 0;
      resp_ready = (hold == 0);
      while (!resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_resp_valid"}, 32'(resp_valid), 1);
      chk({tag, "_latency"}, cyc - acc_edge, exp_lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(resp_valid), 1);
            chk({tag, "_hold_data"}, 32'(resp_data), 32'(e[7:0]));
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 0);
         end
         resp_ready = 1'b1;
      end
      chk({tag, "_data"}, 32'(resp_data), 32'(e[7:0]));
      chk({tag, "_error"}, 32'(resp_error), 32'(e[8]));
      @(negedge clk);
      chk({tag, "_back_idle"}, {30'd0, resp_valid, req_ready}, 32'b01);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      int rd0, wr0, n;
      logic [7:0] ra, rv;

      reset_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_address = 8'h00; req_data = 8'h00;
      resp_ready = 1'b1;
      t_req_valid = 1'b0; t_resp_ready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {27'd0, req_ready, resp_valid, resp_error, mem_read_signal, mem_write_signal}, 0);
      chk("rst_paths", {8'd0, resp_data, mem_address, mem_in}, 0);
      chk("rst_t3_ready", 32'(t_req_ready), 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", {30'd0, req_ready, t_req_ready}, 32'b11);

      // store then load, same address
      rd0 = rd_cnt; wr0 = wr_cnt;
      send(1'b1, 8'h3C, 8'hA5, 8'h00, 1'b1);
      recv("store_3c", 2, 0);
      chk("store_wr_pulses", wr_cnt - wr0, 1);
      chk("store_rd_pulses", rd_cnt - rd0, 0);
      chk("idle_hold_addr", {16'd0, mem_address, mem_in}, {16'd0, 8'h3C, 8'hA5});
      rd0 = rd_cnt; wr0 = wr_cnt;
      send(1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1);
      recv("load_3c", 2, 0);
      chk("load_rd_pulses", rd_cnt - rd0, 1);
      chk("load_wr_pulses", wr_cnt - wr0, 0);

      // stale ready: second load of the same address sees new contents
      send(1'b1, 8'h10, 8'h11, 8'h00, 1'b1);
      recv("store_10", 2, 0);
      send(1'b0, 8'h10, 8'h00, 8'h11, 1'b1);
      recv("load_10_a", 2, 0);
      poke_addr = 8'h10; poke_val = 8'h99; poke_en = 1'b1;
      @(negedge clk);
      poke_en = 1'b0;
      send(1'b0, 8'h10, 8'h00, 8'h99, 1'b1);
      chk("stale_ready_in_issue", {30'd0, mem_ready, mem_read_signal}, 32'b11);
      recv("load_10_b", 2, 0);

      // random address store/load
      ra = 8'($urandom_range(8'h80, 8'hFF));
      rv = 8'($urandom_range(1, 255));
      send(1'b1, ra, rv, 8'h00, 1'b1);
      recv("store_rand", 2, 0);
      send(1'b0, ra, 8'h00, rv, 1'b1);
      recv("load_rand", 2, 0);

      // slow memory: ready low for 4 WAIT cycles
      slow_delay = 4;
      send(1'b1, 8'h44, 8'h5E, 8'h00, 1'b1);
      recv("slow_store", 6, 0);
      send(1'b0, 8'h44, 8'h00, 8'h5E, 1'b1);
      recv("slow_load", 6, 0);
      slow_delay = 0;

      // response backpressure
      send(1'b0, 8'h44, 8'h00, 8'h5E, 1'b1);
      recv("bp_load", 2, 5);

      // reset during WAIT
      slow_delay = 10;
      send(1'b0, 8'h3C, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk("in_wait_before_rst", {30'd0, req_ready, resp_valid}, 0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_wait_ctrl", {27'd0, req_ready, resp_valid, resp_error, mem_read_signal, mem_write_signal}, 0);
      chk("rst_wait_paths", {8'd0, resp_data, mem_address, mem_in}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", {30'd0, req_ready, resp_valid}, 32'b10);
      repeat (3) @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid), 0);
      slow_delay = 0;
      send(1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1);
      recv("after_rst_load", 2, 0);

      // timeout on the TIMEOUT_CYCLES=3 instance
      t_req_valid = 1'b1;
      chk("t3_req_ready", 32'(t_req_ready), 1);
      @(negedge clk);
      t_req_valid = 1'b0;
      chk("t3_read_strobe", 32'(t_mem_read_signal), 1);
      n = 0;
      while (!t_resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t3_wait_cycles", n, 4);
      chk("t3_resp", {23'd0, t_resp_valid, t_resp_error, t_resp_data}, {23'd0, 1'b1, 1'b1, 8'h00});
      t_resp_ready = 1'b1;
      @(negedge clk);
      chk("t3_back_idle", {30'd0, t_resp_valid, t_req_ready}, 32'b01);

      chk("strobes_exclusive", both_cnt, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
